// File: rtl/ship_motion_ctrl.sv
// ============================================================================
// Module  : ship_motion_ctrl
// Brief   : Per-frame ship heading/velocity/position update with rate-limited
//           fire. Optional macro SHIP_FRICTION_EN enables velocity decay.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ship_motion_ctrl #(
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int VMAX       = 24,
  parameter int COOLDOWN   = 8,
  parameter int ROT_PERIOD = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       forward,
  input  logic       backward,
  input  logic       rotate_left,
  input  logic       rotate_right,
  input  logic       shoot,
  output logic [7:0] ship_x,
  output logic [6:0] ship_y,
  output logic [2:0] heading,
  output logic       fire,
  output logic [2:0] fire_heading,
  output logic       busy,
  output logic       update_done
);

  localparam int c_ROT_W  = (ROT_PERIOD > 2) ? $clog2(ROT_PERIOD) : 1;
  localparam int c_COOL_W = (COOLDOWN > 2) ? $clog2(COOLDOWN) : 1;
  localparam logic [11:0]        c_LIM_X = 12'(SCREEN_W * 16);
  localparam logic [11:0]        c_LIM_Y = 12'(SCREEN_H * 16);
  localparam logic signed [6:0]  c_VMAX  = 7'(VMAX);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ROT  = 3'd1,
    S_VEL  = 3'd2,
    S_POS  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_pending;
  logic [11:0]           r_pos_x, r_pos_y;
  logic signed [5:0]     r_vel_x, r_vel_y;
  logic [c_ROT_W-1:0]    r_rot_cnt;
  logic [c_COOL_W-1:0]   r_cool_cnt;

  logic signed [1:0]     w_dx, w_dy;
  logic                  w_thrust;
  logic signed [6:0]     w_tx, w_ty;
  logic signed [5:0]     w_vx_next, w_vy_next;

  function automatic logic signed [5:0] sat(input logic signed [6:0] v);
    if (v > c_VMAX)       return 6'(c_VMAX);
    else if (v < -c_VMAX) return 6'(-c_VMAX);
    else                  return v[5:0];
  endfunction

`ifdef SHIP_FRICTION_EN
  function automatic logic signed [5:0] decay(input logic signed [5:0] v);
    if (v > 6'sd0)      return v - 6'sd1;
    else if (v < 6'sd0) return v + 6'sd1;
    else                return v;
  endfunction
`endif

  // One correction is enough because |vel| is far below either playfield size
  function automatic logic [11:0] wrap(input logic [11:0] pos,
                                       input logic signed [5:0] vel,
                                       input logic [11:0] lim);
    logic signed [13:0] s;
    s = $signed({2'b00, pos}) + $signed({{8{vel[5]}}, vel});
    if (s < 14'sd0)                       s = s + $signed({2'b00, lim});
    else if (s >= $signed({2'b00, lim}))  s = s - $signed({2'b00, lim});
    return 12'(s);
  endfunction

  always_comb begin
    w_dx = 2'sd0;
    w_dy = 2'sd0;
    case (heading)
      3'd0: begin w_dx =  2'sd0; w_dy = -2'sd1; end
      3'd1: begin w_dx =  2'sd1; w_dy = -2'sd1; end
      3'd2: begin w_dx =  2'sd1; w_dy =  2'sd0; end
      3'd3: begin w_dx =  2'sd1; w_dy =  2'sd1; end
      3'd4: begin w_dx =  2'sd0; w_dy =  2'sd1; end
      3'd5: begin w_dx = -2'sd1; w_dy =  2'sd1; end
      3'd6: begin w_dx = -2'sd1; w_dy =  2'sd0; end
      default: begin w_dx = -2'sd1; w_dy = -2'sd1; end
    endcase
    w_thrust = forward ^ backward;
    w_tx = forward ? {{5{w_dx[1]}}, w_dx} : -{{5{w_dx[1]}}, w_dx};
    w_ty = forward ? {{5{w_dy[1]}}, w_dy} : -{{5{w_dy[1]}}, w_dy};
    if (w_thrust) begin
      w_vx_next = sat({r_vel_x[5], r_vel_x} + w_tx);
      w_vy_next = sat({r_vel_y[5], r_vel_y} + w_ty);
    end else begin
`ifdef SHIP_FRICTION_EN
      w_vx_next = decay(r_vel_x);
      w_vy_next = decay(r_vel_y);
`else
      w_vx_next = r_vel_x;
      w_vy_next = r_vel_y;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_pending    <= 1'b0;
      r_pos_x      <= 12'((SCREEN_W / 2) * 16);
      r_pos_y      <= 12'((SCREEN_H / 2) * 16);
      r_vel_x      <= 6'sd0;
      r_vel_y      <= 6'sd0;
      r_rot_cnt    <= '0;
      r_cool_cnt   <= '0;
      heading      <= 3'd0;
      fire         <= 1'b0;
      fire_heading <= 3'd0;
      busy         <= 1'b0;
      update_done  <= 1'b0;
    end else begin
      fire        <= 1'b0;
      update_done <= 1'b0;
      // A single tick arriving mid-sequence is queued; extras are dropped
      if (frame_tick && r_state != S_IDLE) r_pending <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (frame_tick || r_pending) begin
            r_state   <= S_ROT;
            busy      <= 1'b1;
            r_pending <= 1'b0;
          end
        end
        S_ROT: begin
          if (rotate_left ^ rotate_right) begin
            if (r_rot_cnt == '0) begin
              heading   <= rotate_right ? heading + 3'd1 : heading - 3'd1;
              r_rot_cnt <= c_ROT_W'(ROT_PERIOD - 1);
            end else begin
              r_rot_cnt <= r_rot_cnt - 1'b1;
            end
          end else begin
            r_rot_cnt <= '0;
          end
          r_state <= S_VEL;
        end
        S_VEL: begin
          r_vel_x <= w_vx_next;
          r_vel_y <= w_vy_next;
          r_state <= S_POS;
        end
        S_POS: begin
          r_pos_x <= wrap(r_pos_x, r_vel_x, c_LIM_X);
          r_pos_y <= wrap(r_pos_y, r_vel_y, c_LIM_Y);
          if (shoot && r_cool_cnt == '0) begin
            fire         <= 1'b1;
            fire_heading <= heading;
            r_cool_cnt   <= c_COOL_W'(COOLDOWN - 1);
          end else if (r_cool_cnt != '0) begin
            r_cool_cnt <= r_cool_cnt - 1'b1;
          end
          update_done <= 1'b1;
          r_state     <= S_DONE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ship_x = 8'(r_pos_x >> 4);
  assign ship_y = 7'(r_pos_y >> 4);

endmodule

`default_nettype wire

// File: tb/tb_ship_motion_ctrl.sv
// ============================================================================
// Module  : tb_ship_motion_ctrl
// Brief   : Directed self-checking bench for ship_motion_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ship_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       forward = 1'b0, backward = 1'b0;
  logic       rotate_left = 1'b0, rotate_right = 1'b0, shoot = 1'b0;
  logic [7:0] ship_x;
  logic [6:0] ship_y;
  logic [2:0] heading, fire_heading;
  logic       fire, busy, update_done;

  int         errors = 0;
  int         checks = 0;
  logic       tick_fired;
  logic [2:0] tick_fh;
  int         done_cnt;

  always #5 clk = ~clk;

  ship_motion_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .forward      (forward),
    .backward     (backward),
    .rotate_left  (rotate_left),
    .rotate_right (rotate_right),
    .shoot        (shoot),
    .ship_x       (ship_x),
    .ship_y       (ship_y),
    .heading      (heading),
    .fire         (fire),
    .fire_heading (fire_heading),
    .busy         (busy),
    .update_done  (update_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one frame_tick and wait (bounded) for update_done, noting any fire
  task automatic run_tick();
    bit done;
    done       = 1'b0;
    tick_fired = 1'b0;
    tick_fh    = 3'd0;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (fire) begin
        tick_fired = 1'b1;
        tick_fh    = fire_heading;
      end
      if (update_done) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) check("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) run_tick();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_x", ship_x, 80);
    check("rst_y", ship_y, 60);
    check("rst_heading", heading, 0);
    check("rst_busy", busy, 0);
    check("rst_done", update_done, 0);
    check("rst_fire", fire, 0);
    reset = 1'b1;

    for (int k = 1; k <= 3; k++) begin
      run_tick();
      check($sformatf("idle_fire_t%0d", k), tick_fired, 0);
    end
    check("idle_x", ship_x, 80);
    check("idle_y", ship_y, 60);
    check("idle_heading", heading, 0);

    // Latency: tick sampled in cycle T
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    check("lat_busy_t1", busy, 1);
    check("lat_done_t1", update_done, 0);
    @(negedge clk);
    @(negedge clk);
    check("lat_done_t3", update_done, 0);
    @(negedge clk);
    check("lat_done_t4", update_done, 1);
    check("lat_busy_t4", busy, 1);
    @(negedge clk);
    check("lat_done_t5", update_done, 0);
    check("lat_busy_t5", busy, 0);

    rotate_right = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      run_tick();
      check($sformatf("rot_t%0d", k), heading, 1 + (k - 1) / 3);
    end
    rotate_right = 1'b0;

    shoot = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      run_tick();
      check($sformatf("fire_t%0d", k), tick_fired, (k % 8 == 1) ? 1 : 0);
      if (k % 8 == 1) check($sformatf("fire_hd_t%0d", k), tick_fh, 3);
    end
    shoot = 1'b0;

    rotate_left = 1'b1; rotate_right = 1'b1;
    run_ticks(2);
    check("rot_both", heading, 3);
    rotate_right = 1'b0;
    run_tick();
    check("rot_left1", heading, 2);
    rotate_left = 1'b0; run_tick(); rotate_left = 1'b1;
    run_tick();
    check("rot_left2", heading, 1);
    rotate_left = 1'b0; run_tick(); rotate_left = 1'b1;
    run_tick();
    check("rot_left3", heading, 0);
    rotate_left = 1'b0;

    forward = 1'b1;
    for (int k = 1; k <= 52; k++) begin
      run_tick();
      if (k == 10) check("fwd_y_t10", ship_y, 56);
      if (k == 24) check("fwd_y_t24", ship_y, 41);
      if (k == 30) check("fwd_y_t30", ship_y, 32);
      if (k == 51) check("fwd_y_t51", ship_y, 0);
      if (k == 52) check("fwd_y_wrap", ship_y, 119);
    end
    check("fwd_x", ship_x, 80);
    forward = 1'b0;

    backward = 1'b1;
    run_ticks(24);
    check("bwd_y", ship_y, 102);
    backward = 1'b0;
    run_tick();
    check("bwd_stopped", ship_y, 102);

    // Back-to-back ticks: second queued, third dropped
    done_cnt = 0;
    @(negedge clk); frame_tick = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      frame_tick = (i == 2 || i == 3);
      if (update_done) done_cnt++;
    end
    check("b2b_done_cnt", done_cnt, 2);

    rotate_right = 1'b1; run_tick();
    rotate_right = 1'b0; run_tick();
    rotate_right = 1'b1; run_tick();
    rotate_right = 1'b0;
    check("vx_heading", heading, 2);
    forward = 1'b1;
    run_ticks(5);
    forward = 1'b0;
    check("vx_x_thrust", ship_x, 80);
    run_ticks(5);
`ifdef SHIP_FRICTION_EN
    check("vx_x_coast5", ship_x, 81);
`else
    check("vx_x_coast5", ship_x, 82);
`endif
    run_ticks(5);
`ifdef SHIP_FRICTION_EN
    check("vx_x_coast10", ship_x, 81);
`else
    check("vx_x_coast10", ship_x, 84);
`endif
    check("vx_y", ship_y, 102);

    // Asynchronous reset while the sequence sits in VEL
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_x", ship_x, 80);
    check("arst_y", ship_y, 60);
    check("arst_heading", heading, 0);
    check("arst_busy", busy, 0);
    check("arst_done", update_done, 0);
    @(negedge clk); reset = 1'b1;
    run_tick();
    check("arst_post_x", ship_x, 80);
    check("arst_post_y", ship_y, 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ship_motion_ctrl.md
Name: ship_motion_ctrl

Overview:
- Downstream consumer of the keyboard mapping block.
- Turns the level-held forward/backward/rotate_left/rotate_right/shoot controls into ship heading, velocity, on-screen position and rate-limited fire requests.
- Updates once per video frame on a one-cycle frame_tick, using a short multi-cycle update sequence.
- Outputs feed the renderer and the bullet manager.

Parameters:
- SCREEN_W, 160, playfield width in pixels
- SCREEN_H, 120, playfield height in pixels
- VMAX, 24, maximum velocity magnitude per axis, in 1/16-pixel units per frame
- COOLDOWN, 8, frames between consecutive fire pulses
- ROT_PERIOD, 3, frames per heading step while a rotate key is held

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- frame_tick  input  1  one-cycle pulse per frame
- forward  input  1  thrust along heading (level)
- backward  input  1  reverse thrust (level)
- rotate_left  input  1  counter-clockwise rotate (level)
- rotate_right  input  1  clockwise rotate (level)
- shoot  input  1  fire request (level)
- ship_x  output  8  integer pixel X (pos_x >> 4)
- ship_y  output  7  integer pixel Y (pos_y >> 4)
- heading  output  3  0=up, increments clockwise in 45-degree steps
- fire  output  1  one-cycle fire pulse
- fire_heading  output  3  heading latched with fire
- busy  output  1  high while the update sequence runs
- update_done  output  1  one-cycle pulse when new outputs are valid

Behaviour:
- Internal state
  - pos_x, pos_y: 12-bit unsigned, 4 fractional bits.
  - vel_x, vel_y: 6-bit signed.
  - rot_cnt and cool_cnt counters.
- Reset (reset low, asynchronous)
  - pos_x = (SCREEN_W/2)<<4, pos_y = (SCREEN_H/2)<<4, so ship_x=80, ship_y=60.
  - heading=0, vel_x=vel_y=0, rot_cnt=0, cool_cnt=0.
  - fire=0, fire_heading=0, busy=0, update_done=0, pending=0, FSM=IDLE.
  - Reset mid-sequence aborts the sequence immediately; no partial update is kept.
- FSM states: IDLE, ROT, VEL, POS, DONE. One cycle per state.
  - IDLE: frame_tick -> ROT, and busy rises the next cycle.
  - ROT
    - Exactly one of rotate_left/rotate_right held: if rot_cnt==0, heading moves ±1 (mod 8, right=+1) and rot_cnt=ROT_PERIOD-1; otherwise rot_cnt decrements.
    - Neither or both held: rot_cnt=0 and heading is unchanged. A fresh press therefore rotates on the first frame.
  - VEL
    - Direction vector (dx,dy) comes from the new heading: 0:(0,-1) 1:(1,-1) 2:(1,0) 3:(1,1) 4:(0,1) 5:(-1,1) 6:(-1,0) 7:(-1,-1).
    - forward only: vel += (dx,dy). backward only: vel -= (dx,dy).
    - Each component saturates to [-VMAX, +VMAX].
    - Both held, or neither held: thrust is zero (see Optional Feature).
  - POS
    - pos += sign-extended vel.
    - Wrap-around: result <0 adds SCREEN_W*16 (or SCREEN_H*16); result >= limit subtracts it. |vel| < limit, so one correction suffices.
    - Fire: if shoot is held and cool_cnt==0, fire=1 for this cycle, fire_heading=heading, cool_cnt=COOLDOWN-1.
    - Otherwise, if cool_cnt>0, cool_cnt decrements (once per frame).
  - DONE: update_done=1 for one cycle, then IDLE. busy is high from ROT through DONE.
- Latency
  - frame_tick at cycle T: heading valid at T+2, ship_x/ship_y valid at T+4, update_done at T+4, back in IDLE at T+5.
- frame_tick while busy
  - Sets pending. On the return to IDLE, pending is consumed as a tick.
  - Further ticks while pending is already set are dropped.
- Inputs are sampled only in their respective states; changes mid-sequence affect only later states.

Optional Feature:
- Macro: SHIP_FRICTION_EN.
- Defined: in VEL with zero thrust, each nonzero velocity component moves 1 toward 0 per frame.
- Undefined: velocity is held unchanged with zero thrust (pure inertia).
- Thrust and saturation behaviour are identical in both builds.

Test Plan:
- Reset release, 3 ticks with no keys -> ship_x=80, ship_y=60, heading=0, fire never asserted.
- forward held 30 ticks at heading 0 -> vel_y saturates at -24 after tick 24; pos_y decreases by (sum of |vel_y|)/16 pixels, with wrap to ~119 after passing 0.
- rotate_right held 7 ticks, ROT_PERIOD=3 -> heading 0→1 at tick 1, →2 at tick 4, →3 at tick 7; pressing both keys together -> no change.
- shoot held 20 ticks, COOLDOWN=8 -> fire pulses on ticks 1, 9, 17 only, each with fire_heading equal to the current heading.
- Second frame_tick 2 cycles after the first -> processed back-to-back (two update_done pulses); a third tick while pending is dropped.
- Reset asserted in VEL state -> outputs return to reset values asynchronously, busy=0. With SHIP_FRICTION_EN, a vel_x of 5 with no keys decays to 0 after 5 ticks; without it, vel_x stays 5.
